// File: rtl/feeder_pkg.sv
// Shared types and constants for the convolution window feeder.
package feeder_pkg;
  localparam int FEED_N         = 7;
  localparam int FEED_STRIDE    = 3;
  localparam int KROW_W         = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int TIMEOUT_W      = 6;

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, WAIT, FIN} feeder_state_t;

  typedef logic [FEED_STRIDE-1:0][FEED_N:0] lane_vec_t;
endpackage

// File: rtl/feeder_win_buf.sv
// stride x stride pixel register file holding the current window.
// The row-read port zeroes lanes at or beyond the active kernel size.
module feeder_win_buf
  import feeder_pkg::*;
#(
  parameter int N      = FEED_N,
  parameter int stride = FEED_STRIDE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [KROW_W-1:0]      wr_row,
  input  logic [KROW_W-1:0]      wr_col,
  input  logic [N:0]             wr_data,
  input  logic [KROW_W-1:0]      rd_row,
  input  logic [2:0]             ker_len,
  output logic [stride-1:0][N:0] rd_data
);
  logic [N:0] pix [stride][stride];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < stride; r++)
        for (int c = 0; c < stride; c++)
          pix[r][c] <= '0;
    end else if (wr_en && int'(wr_row) < stride && int'(wr_col) < stride) begin
      pix[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < stride; c++)
      if (c < int'(ker_len) && int'(rd_row) < stride)
        rd_data[c] = pix[rd_row][c];
  end
endmodule

// File: rtl/conv_window_feeder.sv
// Raster-order window sequencer feeding the row-vector dot-product unit.
// Define FEEDER_TIMEOUT_EN to give up on a result after 64 silent WAIT cycles.
module conv_window_feeder
  import feeder_pkg::*;
#(
  parameter int N      = FEED_N,
  parameter int stride = FEED_STRIDE,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             ker_len,
  input  logic                   ker_wr_en,
  input  logic [KROW_W-1:0]      ker_wr_row,
  input  logic [stride-1:0][N:0] ker_wr_data,
  output logic                   img_rd_en,
  output logic [ADDR_W-1:0]      img_addr,
  input  logic [N:0]             img_rdata,
  output logic [stride-1:0][N:0] Arr1,
  output logic [stride-1:0][N:0] Arr2,
  output logic                   inp_valid,
  output logic [2:0]             ker_len_o,
  input  logic [2*N+1:0]         dp_in,
  input  logic                   dp_valid,
  output logic [2*N+1:0]         out_data,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  feeder_state_t state, state_nxt;

  logic [stride-1:0][N:0] ker [stride];
  logic [stride-1:0][N:0] win_row, ker_row;
  logic [ADDR_W-1:0]      orow, ocol, cur_idx, ow_last, oh_last;
  logic [KROW_W-1:0]      fr, fc, k, last_k, pend_row, pend_col;
  logic                   drain, pend, start_ok, last_pos, timeout;

  assign start_ok = (ker_len != 3'd0) && (int'(ker_len) <= stride);
  assign last_k   = KROW_W'(ker_len_o - 3'd1);
  assign ow_last  = ADDR_W'(IMG_W - int'(ker_len_o));
  assign oh_last  = ADDR_W'(IMG_H - int'(ker_len_o));
  assign last_pos = (orow == oh_last) && (ocol == ow_last);

  feeder_win_buf #(.N(N), .stride(stride)) u_win_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pend),
    .wr_row  (pend_row),
    .wr_col  (pend_col),
    .wr_data (img_rdata),
    .rd_row  (k),
    .ker_len (ker_len_o),
    .rd_data (win_row)
  );

  // The final read of a window is followed by one idle drain cycle so its data lands.
  always_comb begin
    img_rd_en = (state == FETCH) && !drain;
    img_addr  = '0;
    if (img_rd_en)
      img_addr = ADDR_W'((int'(orow) + int'(fr)) * IMG_W + int'(ocol) + int'(fc));
  end

  always_comb begin
    ker_row = '0;
    for (int c = 0; c < stride; c++)
      if (c < int'(ker_len_o) && int'(k) < stride)
        ker_row[c] = ker[k][c];
  end

  assign inp_valid = (state == EMIT);
  assign Arr1      = inp_valid ? win_row : '0;
  assign Arr2      = inp_valid ? ker_row : '0;

`ifdef FEEDER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (state == WAIT && !dp_valid)
      wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    else
      wait_cnt <= '0;
  end

  assign timeout = (state == WAIT) && !dp_valid &&
                   (wait_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && start_ok) state_nxt = FETCH;
      FETCH:   if (drain) state_nxt = EMIT;
      EMIT:    if (k == last_k) state_nxt = WAIT;
      WAIT:    if (dp_valid || timeout) state_nxt = last_pos ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < stride; r++) ker[r] <= '0;
      ker_len_o <= '0;
      orow      <= '0;
      ocol      <= '0;
      cur_idx   <= '0;
      fr        <= '0;
      fc        <= '0;
      k         <= '0;
      drain     <= 1'b0;
      pend      <= 1'b0;
      pend_row  <= '0;
      pend_col  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pend      <= 1'b0;
      case (state)
        IDLE: begin
          // A same-cycle kernel write still lands before the pass reads it.
          if (ker_wr_en && int'(ker_wr_row) < stride)
            ker[ker_wr_row] <= ker_wr_data;
          if (start) begin
            if (start_ok) begin
              ker_len_o <= ker_len;
              busy      <= 1'b1;
              orow      <= '0;
              ocol      <= '0;
              cur_idx   <= '0;
              fr        <= '0;
              fc        <= '0;
              drain     <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (drain) begin
            drain <= 1'b0;
            k     <= '0;
          end else begin
            pend     <= 1'b1;
            pend_row <= fr;
            pend_col <= fc;
            if (fc == last_k) begin
              fc <= '0;
              if (fr == last_k) begin
                fr    <= '0;
                drain <= 1'b1;
              end else begin
                fr <= fr + KROW_W'(1);
              end
            end else begin
              fc <= fc + KROW_W'(1);
            end
          end
        end
        EMIT: k <= k + KROW_W'(1);
        WAIT: begin
          if (dp_valid || timeout) begin
            out_valid <= 1'b1;
            out_data  <= dp_valid ? dp_in : '0;
            out_idx   <= cur_idx;
            err       <= timeout;
            cur_idx   <= cur_idx + ADDR_W'(1);
            if (ocol == ow_last) begin
              ocol <= '0;
              orow <= orow + ADDR_W'(1);
            end else begin
              ocol <= ocol + ADDR_W'(1);
            end
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
